// File: rtl/acl_pkg.sv
// Shared constants and state encodings for the ADXL362 register poller
// and its single-transaction register master.
package acl_pkg;

    localparam logic [5:0] SOFT_RESET = 6'h1F;
    localparam logic [5:0] POWER_CTL  = 6'h2D;
    localparam logic [5:0] DEVID      = 6'h00;
    localparam logic [5:0] XDATA      = 6'h08;
    localparam logic [5:0] YDATA      = 6'h09;
    localparam logic [5:0] ZDATA      = 6'h0A;
    localparam logic [5:0] TEMP_L     = 6'h14;
    localparam logic [5:0] TEMP_H     = 6'h15;

    localparam logic [7:0] RESET_KEY  = 8'h52;
    localparam logic [7:0] MEASURE    = 8'h02;
    localparam logic [7:0] DEVID_AD   = 8'hAD;

    typedef enum logic [3:0] {
        S_SRST   = 4'd0,
        S_SRWAIT = 4'd1,
        S_PWR    = 4'd2,
        S_ID     = 4'd3,
        S_IDLE   = 4'd4,
        S_RDX    = 4'd5,
        S_RDY    = 4'd6,
        S_RDZ    = 4'd7,
        S_RDTL   = 4'd8,
        S_RDTH   = 4'd9,
        S_PUB    = 4'd10
    } poll_state_e;

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_WR    = 3'd1,
        M_WRESP = 3'd2,
        M_RADDR = 3'd3,
        M_RDATA = 3'd4
    } mst_state_e;

    // Timers never go below 17 bits so the 100k-cycle defaults always fit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 32'd17) ? 32'd17 : w;
    endfunction

endpackage

// File: rtl/acl_reg_master.sv
// Runs one AXI-lite style register transaction (write or read) per start
// request and reports completion with a one-cycle done pulse.
module acl_reg_master
    import acl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [5:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic [1:0] resp,
    output logic       reg_awvalid,
    input  logic       reg_awready,
    output logic [5:0] reg_awaddr,
    output logic       reg_wvalid,
    input  logic       reg_wready,
    output logic [7:0] reg_wdata,
    input  logic       reg_bvalid,
    output logic       reg_bready,
    input  logic [1:0] reg_bresp,
    output logic       reg_arvalid,
    input  logic       reg_arready,
    output logic [5:0] reg_araddr,
    input  logic       reg_rvalid,
    output logic       reg_rready,
    input  logic [7:0] reg_rdata,
    input  logic [1:0] reg_rresp
);

    mst_state_e state_q, state_d;
    logic       awvalid_q, awvalid_d;
    logic       wvalid_q, wvalid_d;
    logic       bready_q, bready_d;
    logic       arvalid_q, arvalid_d;
    logic       rready_q, rready_d;
    logic [5:0] awaddr_q, awaddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [5:0] araddr_q, araddr_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] resp_q, resp_d;

    // Handshake sequencing for the single outstanding transaction.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            M_IDLE: begin
                if (start && we) begin
                    state_d   = M_WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = addr;
                    wdata_d   = wdata;
                end else if (start) begin
                    state_d   = M_RADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = addr;
                end else begin
                    state_d   = M_IDLE;
                end
            end
            M_WR: begin
                // Each valid drops independently once its ready has been seen.
                awvalid_d = awvalid_q && !reg_awready;
                wvalid_d  = wvalid_q && !reg_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = M_WRESP;
                    bready_d = 1'b1;
                end else begin
                    state_d  = M_WR;
                end
            end
            M_WRESP: begin
                if (reg_bvalid) begin
                    bready_d = 1'b0;
                    resp_d   = reg_bresp;
                    done_d   = 1'b1;
                    state_d  = M_IDLE;
                end else begin
                    state_d  = M_WRESP;
                end
            end
            M_RADDR: begin
                // rready rises with the address accept: the bridge needs it before rvalid.
                if (reg_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = M_RDATA;
                end else begin
                    state_d   = M_RADDR;
                end
            end
            M_RDATA: begin
                if (reg_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = reg_rdata;
                    resp_d   = reg_rresp;
                    done_d   = 1'b1;
                    state_d  = M_IDLE;
                end else begin
                    state_d  = M_RDATA;
                end
            end
            default: begin
                state_d   = M_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // Transaction state and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= M_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= 6'h00;
            wdata_q   <= 8'h00;
            araddr_q  <= 6'h00;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            araddr_q  <= araddr_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign reg_awvalid = awvalid_q;
    assign reg_wvalid  = wvalid_q;
    assign reg_bready  = bready_q;
    assign reg_arvalid = arvalid_q;
    assign reg_rready  = rready_q;
    assign reg_awaddr  = awaddr_q;
    assign reg_wdata   = wdata_q;
    assign reg_araddr  = araddr_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign resp        = resp_q;

endmodule

// File: rtl/acl_poller.sv
// Brings up an ADXL362 behind the SPI register bridge, then sweeps X/Y/Z
// periodically. Define ACL_TEMP_EN to add the temperature reads and acl_temp port.
module acl_poller
    import acl_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned RESET_WAIT    = 100000,
    parameter int unsigned ERR_CHECK     = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic        reg_awvalid,
    input  logic        reg_awready,
    output logic [5:0]  reg_awaddr,
    output logic        reg_wvalid,
    input  logic        reg_wready,
    output logic [7:0]  reg_wdata,
    input  logic        reg_bvalid,
    output logic        reg_bready,
    input  logic [1:0]  reg_bresp,
    output logic        reg_arvalid,
    input  logic        reg_arready,
    output logic [5:0]  reg_araddr,
    input  logic        reg_rvalid,
    output logic        reg_rready,
    input  logic [7:0]  reg_rdata,
    input  logic [1:0]  reg_rresp,
    output logic [7:0]  acl_x,
    output logic [7:0]  acl_y,
    output logic [7:0]  acl_z,
    output logic        sample_valid,
    output logic        id_ok,
    output logic        init_done,
    output logic        err
`ifdef ACL_TEMP_EN
    ,
    output logic [11:0] acl_temp
`endif
);

    localparam int unsigned TIMER_W = timer_width(SAMPLE_PERIOD, RESET_WAIT);

    poll_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               busy_q, busy_d;
    logic [7:0]         x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d;
    logic [7:0]         acl_x_q, acl_x_d, acl_y_q, acl_y_d, acl_z_q, acl_z_d;
    logic               sample_valid_q, sample_valid_d;
    logic               id_ok_q, id_ok_d;
    logic               init_done_q, init_done_d;
    logic               err_q, err_d;
`ifdef ACL_TEMP_EN
    logic [7:0]         tl_sh_q, tl_sh_d, th_sh_q, th_sh_d;
    logic [11:0]        acl_temp_q, acl_temp_d;
`endif

    logic               xact_s, mst_start_s, mst_we_s, mst_done_s;
    logic [5:0]         mst_addr_s;
    logic [7:0]         mst_wdata_s, mst_rdata_s;
    logic [1:0]         mst_resp_s;

    acl_reg_master u_master (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .start       (mst_start_s),
        .we          (mst_we_s),
        .addr        (mst_addr_s),
        .wdata       (mst_wdata_s),
        .done        (mst_done_s),
        .rdata       (mst_rdata_s),
        .resp        (mst_resp_s),
        .reg_awvalid (reg_awvalid),
        .reg_awready (reg_awready),
        .reg_awaddr  (reg_awaddr),
        .reg_wvalid  (reg_wvalid),
        .reg_wready  (reg_wready),
        .reg_wdata   (reg_wdata),
        .reg_bvalid  (reg_bvalid),
        .reg_bready  (reg_bready),
        .reg_bresp   (reg_bresp),
        .reg_arvalid (reg_arvalid),
        .reg_arready (reg_arready),
        .reg_araddr  (reg_araddr),
        .reg_rvalid  (reg_rvalid),
        .reg_rready  (reg_rready),
        .reg_rdata   (reg_rdata),
        .reg_rresp   (reg_rresp)
    );

    // Bring-up and sweep sequencing; each bus state issues one request and waits for done.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        busy_d         = busy_q;
        x_sh_d         = x_sh_q;
        y_sh_d         = y_sh_q;
        z_sh_d         = z_sh_q;
        acl_x_d        = acl_x_q;
        acl_y_d        = acl_y_q;
        acl_z_d        = acl_z_q;
        sample_valid_d = 1'b0;
        id_ok_d        = id_ok_q;
        init_done_d    = init_done_q;
        err_d          = err_q;
        xact_s         = 1'b0;
        mst_we_s       = 1'b0;
        mst_addr_s     = 6'h00;
        mst_wdata_s    = 8'h00;
`ifdef ACL_TEMP_EN
        tl_sh_d        = tl_sh_q;
        th_sh_d        = th_sh_q;
        acl_temp_d     = acl_temp_q;
`endif
        case (state_q)
            S_SRST: begin
                xact_s      = 1'b1;
                mst_we_s    = 1'b1;
                mst_addr_s  = SOFT_RESET;
                mst_wdata_s = RESET_KEY;
                if (mst_done_s) state_d = S_SRWAIT;
                else            state_d = S_SRST;
            end
            S_SRWAIT: begin
                if (timer_q == TIMER_W'(RESET_WAIT - 32'd1)) begin
                    timer_d = '0;
                    state_d = S_PWR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_PWR: begin
                xact_s      = 1'b1;
                mst_we_s    = 1'b1;
                mst_addr_s  = POWER_CTL;
                mst_wdata_s = MEASURE;
                if (mst_done_s) state_d = S_ID;
                else            state_d = S_PWR;
            end
            S_ID: begin
                xact_s     = 1'b1;
                mst_addr_s = DEVID;
                if (mst_done_s) begin
                    id_ok_d     = (mst_rdata_s == DEVID_AD);
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                    if (mst_rdata_s != DEVID_AD) err_d = 1'b1;
                    else                         err_d = err_q;
                end else begin
                    state_d = S_ID;
                end
            end
            S_IDLE: begin
                if (timer_q == TIMER_W'(SAMPLE_PERIOD - 32'd1)) begin
                    timer_d = '0;
                    state_d = S_RDX;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_RDX: begin
                xact_s     = 1'b1;
                mst_addr_s = XDATA;
                if (mst_done_s) begin
                    x_sh_d  = mst_rdata_s;
                    state_d = S_RDY;
                end else begin
                    state_d = S_RDX;
                end
            end
            S_RDY: begin
                xact_s     = 1'b1;
                mst_addr_s = YDATA;
                if (mst_done_s) begin
                    y_sh_d  = mst_rdata_s;
                    state_d = S_RDZ;
                end else begin
                    state_d = S_RDY;
                end
            end
            S_RDZ: begin
                xact_s     = 1'b1;
                mst_addr_s = ZDATA;
                if (mst_done_s) begin
                    z_sh_d  = mst_rdata_s;
`ifdef ACL_TEMP_EN
                    state_d = S_RDTL;
`else
                    state_d = S_PUB;
`endif
                end else begin
                    state_d = S_RDZ;
                end
            end
`ifdef ACL_TEMP_EN
            S_RDTL: begin
                xact_s     = 1'b1;
                mst_addr_s = TEMP_L;
                if (mst_done_s) begin
                    tl_sh_d = mst_rdata_s;
                    state_d = S_RDTH;
                end else begin
                    state_d = S_RDTL;
                end
            end
            S_RDTH: begin
                xact_s     = 1'b1;
                mst_addr_s = TEMP_H;
                if (mst_done_s) begin
                    th_sh_d = mst_rdata_s;
                    state_d = S_PUB;
                end else begin
                    state_d = S_RDTH;
                end
            end
`endif
            S_PUB: begin
                acl_x_d        = x_sh_q;
                acl_y_d        = y_sh_q;
                acl_z_d        = z_sh_q;
`ifdef ACL_TEMP_EN
                acl_temp_d     = {th_sh_q[3:0], tl_sh_q};
`endif
                sample_valid_d = 1'b1;
                timer_d        = '0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_SRST;
                timer_d = '0;
            end
        endcase

        // A bad response code is flagged but the returned data is still used.
        mst_start_s = xact_s && !busy_q;
        if (mst_done_s) begin
            busy_d = 1'b0;
            if ((ERR_CHECK != 32'd0) && (mst_resp_s != 2'b00)) err_d = 1'b1;
            else                                               err_d = err_d;
        end else begin
            busy_d = busy_q | mst_start_s;
        end
    end

    // Poller state, timer, shadows and published outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= S_SRST;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            x_sh_q         <= 8'h00;
            y_sh_q         <= 8'h00;
            z_sh_q         <= 8'h00;
            acl_x_q        <= 8'h00;
            acl_y_q        <= 8'h00;
            acl_z_q        <= 8'h00;
            sample_valid_q <= 1'b0;
            id_ok_q        <= 1'b0;
            init_done_q    <= 1'b0;
            err_q          <= 1'b0;
`ifdef ACL_TEMP_EN
            tl_sh_q        <= 8'h00;
            th_sh_q        <= 8'h00;
            acl_temp_q     <= 12'h000;
`endif
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            x_sh_q         <= x_sh_d;
            y_sh_q         <= y_sh_d;
            z_sh_q         <= z_sh_d;
            acl_x_q        <= acl_x_d;
            acl_y_q        <= acl_y_d;
            acl_z_q        <= acl_z_d;
            sample_valid_q <= sample_valid_d;
            id_ok_q        <= id_ok_d;
            init_done_q    <= init_done_d;
            err_q          <= err_d;
`ifdef ACL_TEMP_EN
            tl_sh_q        <= tl_sh_d;
            th_sh_q        <= th_sh_d;
            acl_temp_q     <= acl_temp_d;
`endif
        end
    end

    assign acl_x        = acl_x_q;
    assign acl_y        = acl_y_q;
    assign acl_z        = acl_z_q;
    assign sample_valid = sample_valid_q;
    assign id_ok        = id_ok_q;
    assign init_done    = init_done_q;
    assign err          = err_q;
`ifdef ACL_TEMP_EN
    assign acl_temp     = acl_temp_q;
`endif

endmodule

// File: tb/tb_acl_poller.sv
// Scoreboard bench for acl_poller: a bridge responder checks each bus transaction
// against an expected queue and a monitor checks every sample_valid pulse.
module tb_acl_poller;
    import acl_pkg::*;

    localparam int SP = 20;
    localparam int RW = 12;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       reg_awvalid, reg_wvalid, reg_bready, reg_arvalid, reg_rready;
    logic       reg_awready, reg_wready, reg_bvalid, reg_arready, reg_rvalid;
    logic [5:0] reg_awaddr, reg_araddr;
    logic [7:0] reg_wdata, reg_rdata;
    logic [1:0] reg_bresp, reg_rresp;
    logic [7:0] acl_x, acl_y, acl_z;
    logic       sample_valid, id_ok, init_done, err;
`ifdef ACL_TEMP_EN
    logic [11:0] acl_temp;
`endif

    always #5 sys_clk = ~sys_clk;

    acl_poller #(.SAMPLE_PERIOD(SP), .RESET_WAIT(RW), .ERR_CHECK(1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .reg_awvalid(reg_awvalid), .reg_awready(reg_awready), .reg_awaddr(reg_awaddr),
        .reg_wvalid(reg_wvalid), .reg_wready(reg_wready), .reg_wdata(reg_wdata),
        .reg_bvalid(reg_bvalid), .reg_bready(reg_bready), .reg_bresp(reg_bresp),
        .reg_arvalid(reg_arvalid), .reg_arready(reg_arready), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rready(reg_rready), .reg_rdata(reg_rdata),
        .reg_rresp(reg_rresp),
`ifdef ACL_TEMP_EN
        .acl_temp(acl_temp),
`endif
        .acl_x(acl_x), .acl_y(acl_y), .acl_z(acl_z), .sample_valid(sample_valid),
        .id_ok(id_ok), .init_done(init_done), .err(err)
    );

    typedef struct packed { logic we; logic [5:0] addr; logic [7:0] data; } bus_t;
    typedef struct packed { logic [7:0] x; logic [7:0] y; logic [7:0] z; } smp_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         sv_count = 0;
    int         last_sv_cyc = -1;
    int         last_b_cyc = -1;
    int         ar_delay = 1;
    int         r_delay = 1;
    logic [7:0] regmap [64];
    logic       bad_en = 1'b0;
    logic [5:0] bad_addr = 6'h00;
    logic [5:0] cur_ar = 6'h3F;
    logic       in_read = 1'b0;
    bus_t       exp_bus [$];
    smp_t       exp_smp [$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bus_check(input bus_t got);
        bus_t e;
        if (exp_bus.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL bus_unexpected: got we=%0b addr=%0h data=%0h, none expected", got.we, got.addr, got.data);
        end else begin
            e = exp_bus.pop_front();
            chk("bus_xact", 32'(got), 32'(e));
        end
    endtask

    task automatic bus_idle();
        reg_awready = 1'b0; reg_wready = 1'b0; reg_bvalid = 1'b0; reg_bresp = 2'b00;
        reg_arready = 1'b0; reg_rvalid = 1'b0; reg_rdata = 8'h00; reg_rresp = 2'b00;
        in_read = 1'b0;
    endtask

    task automatic step(output bit aborted);
        @(posedge sys_clk);
        #1;
        aborted = !sys_rst_n;
    endtask

    // One responder iteration: idle cycle, or a full write/read handshake.
    task automatic serve();
        bit ab, ok;
        step(ab);
        if (ab) begin bus_idle(); return; end
        if (reg_awvalid || reg_wvalid) begin
            chk("aw_w_together", {reg_awvalid, reg_wvalid}, 2'b11);
            chk("aw_ar_exclusive", reg_arvalid, 1'b0);
            if (reg_awaddr == POWER_CTL && last_b_cyc >= 0)
                chk("reset_wait_gap", cyc - last_b_cyc, RW + 2);  // done pulse + start issue
            bus_check({1'b1, reg_awaddr, reg_wdata});
            step(ab);
            if (ab) begin bus_idle(); return; end
            reg_awready = 1'b1; reg_wready = 1'b1;
            step(ab);
            reg_awready = 1'b0; reg_wready = 1'b0;
            if (ab) begin bus_idle(); return; end
            chk("aw_w_dropped", {reg_awvalid, reg_wvalid}, 2'b00);
            reg_bvalid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                ok = reg_bready;
                step(ab);
                if (ab) begin bus_idle(); return; end
            end
            chk("bready_seen", ok, 1'b1);
            reg_bvalid = 1'b0;
            last_b_cyc = cyc;
        end else if (reg_arvalid) begin
            chk("ar_aw_exclusive", reg_awvalid | reg_wvalid, 1'b0);
            if (reg_araddr == XDATA && last_sv_cyc >= 0)
                chk("sample_idle_gap", cyc - last_sv_cyc, SP + 1);
            bus_check({1'b0, reg_araddr, 8'h00});
            cur_ar = reg_araddr;
            in_read = 1'b1;
            ok = 1'b1;
            for (int i = 0; i < ar_delay; i++) begin
                step(ab);
                if (ab) begin bus_idle(); return; end
                ok = ok & reg_arvalid;
            end
            chk("arvalid_held", ok, 1'b1);
            reg_arready = 1'b1;
            step(ab);
            reg_arready = 1'b0;
            if (ab) begin bus_idle(); return; end
            ok = 1'b1;
            for (int i = 0; i < r_delay; i++) begin
                ok = ok & reg_rready & !reg_arvalid;
                step(ab);
                if (ab) begin bus_idle(); return; end
            end
            ok = ok & reg_rready & !reg_arvalid;
            chk("rready_held_no_dup_ar", ok, 1'b1);
            reg_rvalid = 1'b1;
            reg_rdata  = regmap[cur_ar];
            reg_rresp  = (bad_en && cur_ar == bad_addr) ? 2'b10 : 2'b00;
            step(ab);
            reg_rvalid = 1'b0; reg_rresp = 2'b00; in_read = 1'b0;
            if (ab) begin bus_idle(); return; end
        end
    endtask

    initial begin
        bus_idle();
        forever serve();
    end

    // Sample monitor.
    initial begin
        smp_t e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && sample_valid) begin
                if (exp_smp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sample_unexpected: got %0h/%0h/%0h, none expected", acl_x, acl_y, acl_z);
                end else begin
                    e = exp_smp.pop_front();
                    chk("sample_xyz", {8'h00, acl_x, acl_y, acl_z}, {8'h00, e.x, e.y, e.z});
                end
                sv_count++;
                last_sv_cyc = cyc;
            end
        end
    end

    task automatic wait_samples(input int n);
        int target;
        target = sv_count + n;
        for (int i = 0; i < 3000 && sv_count < target; i++) @(negedge sys_clk);
        if (sv_count < target) begin
            vectors++;
            miscompares++;
            $display("FAIL sample_timeout: got %0d pulses expected %0d", sv_count, target);
        end
    endtask

    task automatic push_bringup();
        exp_bus.push_back({1'b1, SOFT_RESET, RESET_KEY});
        exp_bus.push_back({1'b1, POWER_CTL, MEASURE});
        exp_bus.push_back({1'b0, DEVID, 8'h00});
    endtask

    task automatic push_sweep(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        exp_bus.push_back({1'b0, XDATA, 8'h00});
        exp_bus.push_back({1'b0, YDATA, 8'h00});
        exp_bus.push_back({1'b0, ZDATA, 8'h00});
        exp_smp.push_back({x, y, z});
    endtask

    task automatic set_xyz(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        regmap[XDATA] = x; regmap[YDATA] = y; regmap[ZDATA] = z;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {reg_awvalid, reg_wvalid, reg_bready, reg_arvalid, reg_rready},
            5'b00000);
        chk({tag, "_flags"}, {sample_valid, id_ok, init_done, err}, 4'b0000);
        chk({tag, "_xyz"}, {acl_x, acl_y, acl_z}, 24'h000000);
    endtask

    task automatic enter_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        exp_bus.delete();
        exp_smp.delete();
        last_sv_cyc = -1;
        last_b_cyc = -1;
        @(negedge sys_clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regmap[i] = 8'h00;
        repeat (3) @(negedge sys_clk);
        chk_reset_outputs("por");

        // Good ID, fast bridge, two sweeps.
        regmap[DEVID] = DEVID_AD;
        set_xyz(8'h11, 8'hF0, 8'h40);
        push_bringup();
        push_sweep(8'h11, 8'hF0, 8'h40);
        push_sweep(8'h11, 8'hF0, 8'h40);
        sys_rst_n = 1'b1;
        wait_samples(1);
        chk("init_flags", {id_ok, init_done, err}, 3'b110);
        wait_samples(1);

        // Slow bridge: arready after 5 cycles, rvalid after 40.
        ar_delay = 5; r_delay = 40;
        set_xyz(8'h22, 8'h33, 8'h44);
        push_sweep(8'h22, 8'h33, 8'h44);
        wait_samples(1);
        chk("slow_err_clear", err, 1'b0);
        ar_delay = 1; r_delay = 1;

        // Bad rresp on YDATA: err sticky, sample still published.
        bad_addr = YDATA; bad_en = 1'b1;
        set_xyz(8'h01, 8'h02, 8'h03);
        push_sweep(8'h01, 8'h02, 8'h03);
        wait_samples(1);
        chk("rresp_err", err, 1'b1);
        bad_en = 1'b0;
        set_xyz(8'h04, 8'h05, 8'h06);
        push_sweep(8'h04, 8'h05, 8'h06);
        wait_samples(1);
        chk("err_sticky", {id_ok, err}, 2'b11);

        // Wrong device ID: err set, polling still runs.
        enter_reset();
        chk_reset_outputs("rst2");
        regmap[DEVID] = 8'h12;
        set_xyz(8'h7A, 8'h7B, 8'h7C);
        push_bringup();
        push_sweep(8'h7A, 8'h7B, 8'h7C);
        sys_rst_n = 1'b1;
        wait_samples(1);
        chk("bad_id_flags", {id_ok, init_done, err}, 3'b011);

        // Reset in the middle of the YDATA read.
        ar_delay = 5;
        exp_bus.push_back({1'b0, XDATA, 8'h00});
        exp_bus.push_back({1'b0, YDATA, 8'h00});
        for (int i = 0; i < 500 && !(in_read && cur_ar == YDATA); i++) @(negedge sys_clk);
        chk("reached_rdy", {in_read, 2'b00, cur_ar}, {1'b1, 2'b00, YDATA});
        enter_reset();
        chk_reset_outputs("rst_mid");
        repeat (3) @(negedge sys_clk);
        chk("rst_no_sample", sample_valid, 1'b0);
        ar_delay = 1;
        regmap[DEVID] = DEVID_AD;
        set_xyz(8'h55, 8'h66, 8'h77);
        push_bringup();
        push_sweep(8'h55, 8'h66, 8'h77);
        sys_rst_n = 1'b1;
        wait_samples(1);
        chk("restart_flags", {id_ok, init_done, err}, 3'b110);

        chk("bus_queue_drained", exp_bus.size(), 0);
        chk("sample_queue_drained", exp_smp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/acl_poller.md
Name: acl_poller

Overview:
- AXI-lite style register master that drives the 6-bit-address / 8-bit-data register port of the accelerometer SPI bridge.
- After reset it brings up the ADXL362:
  - soft reset;
  - enter measurement mode;
  - check the device ID.
- It then periodically reads the X/Y/Z 8-bit data registers and publishes one sample-valid pulse per sweep to downstream display/processing logic.

Parameters:
- SAMPLE_PERIOD, 100000, sys_clk cycles spent idle between sweeps (1 ms at 100 MHz); must be >= 1.
- RESET_WAIT, 100000, cycles to wait after the soft-reset write before the power-control write.
- ERR_CHECK, 1, when 1, nonzero bresp/rresp sets err.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous active-low reset
- reg_awvalid  out  1  write address valid
- reg_awready  in  1  write address accepted
- reg_awaddr  out  6  write register address
- reg_wvalid  out  1  write data valid
- reg_wready  in  1  write data accepted
- reg_wdata  out  8  write data
- reg_bvalid  in  1  write response valid
- reg_bready  out  1  write response ready
- reg_bresp  in  2  write response code
- reg_arvalid  out  1  read address valid
- reg_arready  in  1  read address accepted
- reg_araddr  out  6  read register address
- reg_rvalid  in  1  read data valid
- reg_rready  out  1  read data ready
- reg_rdata  in  8  read data
- reg_rresp  in  2  read response code
- acl_x  out  8  X sample (reg 0x08)
- acl_y  out  8  Y sample (reg 0x09)
- acl_z  out  8  Z sample (reg 0x0A)
- sample_valid  out  1  one-cycle pulse; all sample outputs updated together
- id_ok  out  1  device ID read equalled 0xAD
- init_done  out  1  high once bring-up completes, stays high until reset
- err  out  1  sticky: bad response code or ID mismatch

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge):
  - all valids/readies, sample_valid, id_ok, init_done and err go to 0;
  - acl_x/y/z go to 0x00;
  - FSM goes to S_SRST; timers clear.
  - Reset mid-transaction simply abandons the transaction; the bridge is reset by the same system reset.
- Write transaction:
  - assert awvalid and wvalid together with addr/data stable;
  - drop each valid the cycle after its ready is sampled high (the bridge returns both readies together, after the SPI frame completes);
  - then hold bready=1 until bvalid is sampled; transaction ends that cycle.
- Read transaction:
  - assert arvalid until arready is sampled, then drop it;
  - hold rready=1 from arready until rvalid is sampled;
  - capture rdata on that cycle.
  - rready must already be high before the bridge finishes, because the bridge only issues rvalid while rready is high.
- Only one transaction is outstanding at a time. aw/w and ar are never asserted simultaneously.
- FSM states and transitions:
  - S_SRST: write 0x1F=0x52 -> S_SRWAIT.
  - S_SRWAIT: count RESET_WAIT cycles -> S_PWR.
  - S_PWR: write 0x2D=0x02 -> S_ID.
  - S_ID: read 0x00; id_ok = (rdata==0xAD); on mismatch set err but continue -> S_IDLE with init_done=1.
  - S_IDLE: count SAMPLE_PERIOD cycles -> S_RDX.
  - S_RDX / S_RDY / S_RDZ: read 0x08 / 0x09 / 0x0A into shadow registers.
  - S_PUB: copy shadows to acl_x/y/z, pulse sample_valid for 1 cycle -> S_IDLE (timer restarts at 0).
- Outputs change only in S_PUB; a partial sweep is never published.
- Response codes: bresp/rresp != 0 with ERR_CHECK=1 sets err; the data is still used and the sequence continues.
- Timers are 17-bit minimum, sized with $clog2 of the larger parameter. Terminal count is value-1; no wrap beyond that.
- A bridge that never responds stalls the FSM indefinitely (no timeout).

Optional Feature:
- Macro: ACL_TEMP_EN.
- Defined:
  - adds port acl_temp out 12;
  - the sweep adds S_RDTL (read 0x14) and S_RDTH (read 0x15) after S_RDZ;
  - acl_temp = {TH[3:0], TL}, published in S_PUB with the other samples.
- Undefined: no acl_temp port and the sweep is X/Y/Z only.

Decomposition:
- Package acl_pkg holds:
  - register address localparams (SOFT_RESET 0x1F, POWER_CTL 0x2D, DEVID 0x00, XDATA 0x08, YDATA 0x09, ZDATA 0x0A, TEMP_L 0x14, TEMP_H 0x15);
  - data constants (RESET_KEY 0x52, MEASURE 0x02, DEVID_AD 0xAD);
  - the poller state enum.
- Sub-module acl_reg_master handles a single AXI-lite transaction:
  - inputs: start, we, addr, wdata;
  - outputs: done pulse, rdata, resp.
  - acl_poller sequences it.

Test Plan:
- Reset release with a bridge model returning 0xAD for DEVID -> write 0x1F/0x52, RESET_WAIT-cycle gap, write 0x2D/0x02, read 0x00; then id_ok=1, init_done=1, err=0.
- Model returns 0x12 for DEVID -> id_ok=0, err=1, polling still starts.
- Model XDATA=0x11, YDATA=0xF0, ZDATA=0x40 -> exactly one sample_valid pulse with those values. The next pulse comes SAMPLE_PERIOD idle cycles plus transaction time later.
- Model delays arready 5 cycles and rvalid 40 cycles -> arvalid held until arready; rready high continuously until rvalid; no duplicate address issued.
- Model returns rresp=2'b10 on YDATA -> err=1 sticky; sample still published.
- Assert sys_rst_n=0 during S_RDY -> next cycle all outputs at reset values and no sample_valid. After release, bring-up restarts from the soft-reset write.
